// File: rtl/aac_row_sequencer.sv
// ---------------------------------------------------------------------------
// aac_row_sequencer
//
// Purpose:
//   Feeds a stream of signed 28-bit column products into the split
//   adder-accumulator (AAC) one matrix-vector row at a time. The first term
//   of each row restarts the AAC sum and later terms accumulate. Each
//   finished row sum is captured from the AAC and offered on a one-entry
//   valid/ready result port tagged with its row index.
//
// Ports:
//   clk, reset_n         clock (posedge) and asynchronous active-low reset
//   start                1-cycle job request, honoured only while idle
//   cfg_len, cfg_rows    terms per row (1..MAX_COLS), rows per job (>= 1)
//   busy                 high while a job is in progress
//   cfg_err              1-cycle pulse when start carries an illegal config
//   done                 1-cycle pulse after the final result handshake
//   prod_valid/ready     product input handshake, prod_data is the product
//   aac_o, acc_a_o       AAC mode (0 restart, 1 accumulate) and addend
//   acc_out_i            AAC sum, valid one cycle after a row's last term
//   res_valid/ready      result output handshake
//   res_data, res_row    row sum (modulo 2^28) and its row index
// ---------------------------------------------------------------------------
module aac_row_sequencer #(
  parameter  int MAX_COLS = 128,
  parameter  int ROW_W    = 8,
  localparam int LEN_W    = $clog2(MAX_COLS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [ROW_W-1:0] cfg_rows,
  output logic             busy,
  output logic             cfg_err,
  output logic             done,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [27:0]      prod_data,
  output logic             aac_o,
  output logic [27:0]      acc_a_o,
  input  logic [27:0]      acc_out_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [27:0]      res_data,
  output logic [ROW_W-1:0] res_row
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [LEN_W-1:0]   r_len;
  logic [ROW_W-1:0]   r_rows;
  logic [LEN_W-1:0]   r_colCnt;
  logic [ROW_W-1:0]   r_rowCnt;
  logic               r_rowOpen;
  logic               r_capPend;
  logic               r_cfgErr;
  logic               r_done;
  logic               r_resValid;
  logic [27:0]        r_resData;
  logic [ROW_W-1:0]   r_resRow;

  logic               w_cfgLegal;
  logic               w_lastCol;
  logic               w_lastRow;
  logic               w_bufBlocked;
  logic               w_accept;
  logic               w_startOk;
  logic               w_startErr;
  logic               w_finish;

  assign w_cfgLegal   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_COLS)) &&
                        (cfg_rows != '0);
  assign w_lastCol    = (r_colCnt == (r_len - LEN_W'(1)));
  assign w_lastRow    = (r_rowCnt == (r_rows - ROW_W'(1)));
  // The result buffer stays occupied into the next cycle unless it is
  // handed off right now.
  assign w_bufBlocked = r_resValid && !res_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state, product handshake and AAC drive. A row's last term is only
  // accepted when the capture one cycle later is guaranteed to find the
  // result buffer free. Without an accept the AAC sees a zero addend in its
  // current mode, so an open row keeps its sum across bubbles.
  always_comb begin
    w_nextState = r_state;
    prod_ready  = 1'b0;
    w_accept    = 1'b0;
    aac_o       = r_rowOpen;
    acc_a_o     = '0;
    w_startOk   = 1'b0;
    w_startErr  = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfgLegal) begin
            w_startOk   = 1'b1;
            w_nextState = S_RUN;
          end else begin
            w_startErr  = 1'b1;
          end
        end
      end
      S_RUN: begin
        prod_ready = !w_lastCol || (!r_capPend && !w_bufBlocked);
        if (prod_valid && prod_ready) begin
          w_accept = 1'b1;
          aac_o    = (r_colCnt != '0);
          acc_a_o  = prod_data;
          if (w_lastCol && w_lastRow) begin
            w_nextState = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!r_capPend && r_resValid && res_ready) begin
          w_finish    = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Job configuration, column/row counters and the capture request that
  // follows every row's last term by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len     <= '0;
      r_rows    <= '0;
      r_colCnt  <= '0;
      r_rowCnt  <= '0;
      r_rowOpen <= 1'b0;
      r_capPend <= 1'b0;
      r_cfgErr  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_capPend <= 1'b0;
      r_cfgErr  <= w_startErr;
      r_done    <= w_finish;
      if (w_startOk) begin
        r_len     <= cfg_len;
        r_rows    <= cfg_rows;
        r_colCnt  <= '0;
        r_rowCnt  <= '0;
        r_rowOpen <= 1'b0;
      end else if (w_accept) begin
        if (w_lastCol) begin
          r_colCnt  <= '0;
          r_rowOpen <= 1'b0;
          r_capPend <= 1'b1;
          r_rowCnt  <= r_rowCnt + ROW_W'(1);
        end else begin
          r_colCnt  <= r_colCnt + LEN_W'(1);
          r_rowOpen <= 1'b1;
        end
      end
    end
  end

  // One-entry result buffer. The row counter has already advanced when the
  // capture happens, so the captured row index is one behind it. A capture
  // wins over a simultaneous handshake and overwrites the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resRow   <= '0;
    end else if (r_capPend) begin
      r_resValid <= 1'b1;
      r_resData  <= acc_out_i;
      r_resRow   <= r_rowCnt - ROW_W'(1);
    end else if (r_resValid && res_ready) begin
      r_resValid <= 1'b0;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign cfg_err   = r_cfgErr;
  assign done      = r_done;
  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign res_row   = r_resRow;

endmodule

// File: tb/tb_aac_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aac_row_sequencer
//
// Drives product streams into aac_row_sequencer, models the external AAC as
// a registered restart/accumulate adder, and compares every row result
// against sums computed from the driven terms.
// ---------------------------------------------------------------------------
module tb_aac_row_sequencer;

  localparam int LEN_W = 8;
  localparam int ROW_W = 8;

  typedef struct {
    logic [ROW_W-1:0] row;
    logic [27:0]      data;
  } exp_t;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             start     = 1'b0;
  logic [LEN_W-1:0] cfgLen    = '0;
  logic [ROW_W-1:0] cfgRows   = '0;
  logic             prodValid = 1'b0;
  logic [27:0]      prodData  = '0;
  logic             resReady  = 1'b0;
  logic             busy;
  logic             cfgErr;
  logic             done;
  logic             prodReady;
  logic             aacO;
  logic [27:0]      accA;
  logic [27:0]      accOut;
  logic             resValid;
  logic [27:0]      resData;
  logic [ROW_W-1:0] resRow;

  logic [27:0]      aacSum = '0;

  int vectorCount  = 0;
  int missCount    = 0;
  int timeoutCount = 0;
  int cycleCount   = 0;

  exp_t             expQ[$];
  logic [27:0]      obsData  [0:63];
  logic [ROW_W-1:0] obsRow   [0:63];
  int               obsCycle [0:63];
  int               obsCount  = 0;
  int               rdPtr     = 0;
  int               doneCount = 0;
  int               doneCycle = 0;

  aac_row_sequencer #(
    .MAX_COLS (128),
    .ROW_W    (ROW_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .cfg_len    (cfgLen),
    .cfg_rows   (cfgRows),
    .busy       (busy),
    .cfg_err    (cfgErr),
    .done       (done),
    .prod_valid (prodValid),
    .prod_ready (prodReady),
    .prod_data  (prodData),
    .aac_o      (aacO),
    .acc_a_o    (accA),
    .acc_out_i  (accOut),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .res_data   (resData),
    .res_row    (resRow)
  );

  always #5 clk = ~clk;

  // External AAC: restart or accumulate on every edge, sum visible next cycle.
  always @(posedge clk) aacSum <= aacO ? (aacSum + accA) : accA;
  assign accOut = aacSum;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Record result handshakes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && resValid && resReady && obsCount < 64) begin
      obsData[obsCount]  = resData;
      obsRow[obsCount]   = resRow;
      obsCycle[obsCount] = cycleCount;
      obsCount           = obsCount + 1;
    end
    if (reset_n && done) begin
      doneCount = doneCount + 1;
      doneCycle = cycleCount;
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic startJob(input logic [LEN_W-1:0] len, input logic [ROW_W-1:0] rows);
    start   = 1'b1;
    cfgLen  = len;
    cfgRows = rows;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic sendTerm(input logic [27:0] d, output logic aacSeen, output logic [27:0] aSeen);
    int n;
    n         = 0;
    prodValid = 1'b1;
    prodData  = d;
    @(negedge clk);
    while (!prodReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!prodReady) timeoutCount++;
    aacSeen = aacO;
    aSeen   = accA;
    @(posedge clk); #1;
    prodValid = 1'b0;
    prodData  = '0;
  endtask

  task automatic waitDone(input int prevDone);
    int n;
    n = 0;
    while (doneCount == prevDone && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    prodValid = 1'b1;
    prodData  = 28'h1234567;
    resReady  = 1'b1;
    @(negedge clk);
    vectorCount++;
    if ({busy, cfgErr, done, prodReady, aacO, resValid} !== 6'b0) begin
      missCount++;
      $display("[TB] FAIL reset_ctrl: got %b, need 000000", {busy, cfgErr, done, prodReady, aacO, resValid});
    end
    vectorCount++;
    if (accA !== 28'h0) begin
      missCount++;
      $display("[TB] FAIL reset_acc_a: got 0x%07h, need 0x0000000", accA);
    end
    vectorCount++;
    if (resData !== 28'h0 || resRow !== '0) begin
      missCount++;
      $display("[TB] FAIL reset_res: got data 0x%07h row %0d, need 0 row 0", resData, resRow);
    end
    @(posedge clk); #1;
    reset_n   = 1'b1;
    prodValid = 1'b0;
    prodData  = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [27:0] t [8];
    logic [27:0] s;
    logic        aacSeen;
    logic [27:0] aSeen;
    int          prev;
    int          lastIdx;
    exp_t        e;
    t    = '{28'd1, 28'd2, 28'd3, 28'd4, 28'd10, 28'd20, 28'd30, 28'd40};
    prev = doneCount;
    resReady = 1'b1;
    startJob(8'd4, 8'd2);
    for (int r = 0; r < 2; r++) begin
      s = '0;
      for (int c = 0; c < 4; c++) s = s + t[r*4+c];
      expQ.push_back('{row: ROW_W'(r), data: s});
    end
    for (int i = 0; i < 8; i++) begin
      sendTerm(t[i], aacSeen, aSeen);
      vectorCount++;
      if (aacSeen !== ((i % 4) != 0) || aSeen !== t[i]) begin
        missCount++;
        $display("[TB] FAIL basic_drive[%0d]: got aac %b A 0x%07h, need aac %b A 0x%07h",
                 i, aacSeen, aSeen, ((i % 4) != 0), t[i]);
      end
    end
    waitDone(prev);
    vectorCount++;
    if (doneCount !== prev + 1) begin
      missCount++;
      $display("[TB] FAIL basic_done: got %0d pulses, need 1", doneCount - prev);
    end
    lastIdx = obsCount - 1;
    vectorCount++;
    if (lastIdx < 0 || doneCycle !== obsCycle[lastIdx] + 1) begin
      missCount++;
      $display("[TB] FAIL basic_done_timing: got done cycle %0d, need one after handshake", doneCycle);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectorCount++;
      if (rdPtr >= obsCount) begin
        missCount++;
        $display("[TB] FAIL basic_result: got none, need row %0d data 0x%07h", e.row, e.data);
      end else begin
        if (obsRow[rdPtr] !== e.row || obsData[rdPtr] !== e.data) begin
          missCount++;
          $display("[TB] FAIL basic_result: got row %0d data 0x%07h, need row %0d data 0x%07h",
                   obsRow[rdPtr], obsData[rdPtr], e.row, e.data);
        end
        rdPtr++;
      end
    end
  endtask

  task automatic test_bubbles;
    logic [27:0] t [3];
    logic [27:0] s;
    logic        aacSeen;
    logic [27:0] aSeen;
    int          prev;
    int          gap;
    exp_t        e;
    t    = '{28'hFFFFFFB, 28'h7FFFFFF, 28'd7};
    prev = doneCount;
    resReady = 1'b1;
    startJob(8'd3, 8'd1);
    s = t[0] + t[1] + t[2];
    expQ.push_back('{row: '0, data: s});
    @(negedge clk);
    vectorCount++;
    if (aacO !== 1'b0 || accA !== 28'h0) begin
      missCount++;
      $display("[TB] FAIL bubble_pre_row: got aac %b A 0x%07h, need aac 0 A 0", aacO, accA);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sendTerm(t[i], aacSeen, aSeen);
      vectorCount++;
      if (aacSeen !== (i != 0) || aSeen !== t[i]) begin
        missCount++;
        $display("[TB] FAIL bubble_drive[%0d]: got aac %b A 0x%07h, need aac %b A 0x%07h",
                 i, aacSeen, aSeen, (i != 0), t[i]);
      end
      if (i < 2) begin
        gap = int'($urandom_range(3, 1));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          vectorCount++;
          if (aacO !== 1'b1 || accA !== 28'h0) begin
            missCount++;
            $display("[TB] FAIL bubble_hold: got aac %b A 0x%07h, need aac 1 A 0", aacO, accA);
          end
          @(posedge clk); #1;
        end
      end
    end
    waitDone(prev);
    vectorCount++;
    if (doneCount !== prev + 1) begin
      missCount++;
      $display("[TB] FAIL bubble_done: got %0d pulses, need 1", doneCount - prev);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectorCount++;
      if (rdPtr >= obsCount) begin
        missCount++;
        $display("[TB] FAIL bubble_result: got none, need row %0d data 0x%07h", e.row, e.data);
      end else begin
        if (obsRow[rdPtr] !== e.row || obsData[rdPtr] !== e.data) begin
          missCount++;
          $display("[TB] FAIL bubble_result: got row %0d data 0x%07h, need row %0d data 0x%07h",
                   obsRow[rdPtr], obsData[rdPtr], e.row, e.data);
        end
        rdPtr++;
      end
    end
  endtask

  task automatic test_len_one;
    logic [27:0] t [3];
    logic [4:0]  pattern;
    logic        acc;
    int          idx;
    int          prev;
    exp_t        e;
    t    = '{28'd5, 28'd6, 28'd7};
    prev = doneCount;
    resReady = 1'b1;
    startJob(8'd1, 8'd3);
    for (int r = 0; r < 3; r++) expQ.push_back('{row: ROW_W'(r), data: t[r]});
    idx       = 0;
    pattern   = '0;
    prodValid = 1'b1;
    prodData  = t[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc            = prodReady;
      pattern[4 - i] = prodReady;
      @(posedge clk); #1;
      if (acc && idx < 3) begin
        idx++;
        if (idx < 3) begin
          prodData = t[idx];
        end else begin
          prodValid = 1'b0;
          prodData  = '0;
        end
      end
    end
    prodValid = 1'b0;
    vectorCount++;
    if (pattern !== 5'b10101) begin
      missCount++;
      $display("[TB] FAIL len1_ready_pattern: got %b, need 10101", pattern);
    end
    waitDone(prev);
    vectorCount++;
    if (doneCount !== prev + 1) begin
      missCount++;
      $display("[TB] FAIL len1_done: got %0d pulses, need 1", doneCount - prev);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectorCount++;
      if (rdPtr >= obsCount) begin
        missCount++;
        $display("[TB] FAIL len1_result: got none, need row %0d data 0x%07h", e.row, e.data);
      end else begin
        if (obsRow[rdPtr] !== e.row || obsData[rdPtr] !== e.data) begin
          missCount++;
          $display("[TB] FAIL len1_result: got row %0d data 0x%07h, need row %0d data 0x%07h",
                   obsRow[rdPtr], obsData[rdPtr], e.row, e.data);
        end
        rdPtr++;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [27:0] t [6];
    logic [27:0] row0Sum;
    logic        aacSeen;
    logic [27:0] aSeen;
    int          prev;
    exp_t        e;
    t    = '{28'd1, 28'd2, 28'd100, 28'd200, 28'hFFFFFFF, 28'hFFFFFFE};
    prev = doneCount;
    resReady = 1'b0;
    startJob(8'd2, 8'd3);
    for (int r = 0; r < 3; r++) expQ.push_back('{row: ROW_W'(r), data: t[2*r] + t[2*r+1]});
    row0Sum = t[0] + t[1];
    sendTerm(t[0], aacSeen, aSeen);
    sendTerm(t[1], aacSeen, aSeen);
    sendTerm(t[2], aacSeen, aSeen);
    prodValid = 1'b1;
    prodData  = t[3];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectorCount++;
      if ({prodReady, resValid, resRow, resData} !== {1'b0, 1'b1, 8'd0, row0Sum}) begin
        missCount++;
        $display("[TB] FAIL stall_hold[%0d]: got ready %b valid %b row %0d data 0x%07h, need ready 0 valid 1 row 0 data 0x%07h",
                 i, prodReady, resValid, resRow, resData, row0Sum);
      end
      @(posedge clk); #1;
    end
    resReady = 1'b1;
    for (int i = 3; i < 6; i++) sendTerm(t[i], aacSeen, aSeen);
    waitDone(prev);
    vectorCount++;
    if (doneCount !== prev + 1) begin
      missCount++;
      $display("[TB] FAIL stall_done: got %0d pulses, need 1", doneCount - prev);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectorCount++;
      if (rdPtr >= obsCount) begin
        missCount++;
        $display("[TB] FAIL stall_result: got none, need row %0d data 0x%07h", e.row, e.data);
      end else begin
        if (obsRow[rdPtr] !== e.row || obsData[rdPtr] !== e.data) begin
          missCount++;
          $display("[TB] FAIL stall_result: got row %0d data 0x%07h, need row %0d data 0x%07h",
                   obsRow[rdPtr], obsData[rdPtr], e.row, e.data);
        end
        rdPtr++;
      end
    end
  endtask

  task automatic test_cfg_errors;
    logic [LEN_W-1:0] badLen  [3];
    logic [ROW_W-1:0] badRows [3];
    logic             aacSeen;
    logic [27:0]      aSeen;
    int               prev;
    exp_t             e;
    badLen   = '{8'd0, 8'd129, 8'd4};
    badRows  = '{8'd1, 8'd1, 8'd0};
    resReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      startJob(badLen[i], badRows[i]);
      @(negedge clk);
      vectorCount++;
      if (cfgErr !== 1'b1 || busy !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL cfg_err[%0d]: got err %b busy %b, need err 1 busy 0", i, cfgErr, busy);
      end
      @(posedge clk); #1;
    end
    prev = doneCount;
    startJob(8'd2, 8'd1);
    expQ.push_back('{row: '0, data: 28'd8 + 28'd9});
    @(negedge clk);
    vectorCount++;
    if (cfgErr !== 1'b0 || busy !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL cfg_legal: got err %b busy %b, need err 0 busy 1", cfgErr, busy);
    end
    @(posedge clk); #1;
    startJob(8'd1, 8'd5);
    @(negedge clk);
    vectorCount++;
    if (cfgErr !== 1'b0 || busy !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL start_while_busy: got err %b busy %b, need err 0 busy 1", cfgErr, busy);
    end
    @(posedge clk); #1;
    sendTerm(28'd8, aacSeen, aSeen);
    sendTerm(28'd9, aacSeen, aSeen);
    waitDone(prev);
    vectorCount++;
    if (doneCount !== prev + 1 || busy !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL cfg_job_done: got %0d pulses busy %b, need 1 pulse busy 0", doneCount - prev, busy);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectorCount++;
      if (rdPtr >= obsCount) begin
        missCount++;
        $display("[TB] FAIL cfg_result: got none, need row %0d data 0x%07h", e.row, e.data);
      end else begin
        if (obsRow[rdPtr] !== e.row || obsData[rdPtr] !== e.data) begin
          missCount++;
          $display("[TB] FAIL cfg_result: got row %0d data 0x%07h, need row %0d data 0x%07h",
                   obsRow[rdPtr], obsData[rdPtr], e.row, e.data);
        end
        rdPtr++;
      end
    end
    vectorCount++;
    if (obsCount !== rdPtr) begin
      missCount++;
      $display("[TB] FAIL cfg_extra_results: got %0d results, need %0d", obsCount, rdPtr);
    end
  endtask

  task automatic test_reset_midjob;
    logic [27:0] s;
    logic        aacSeen;
    logic [27:0] aSeen;
    int          prev;
    exp_t        e;
    resReady = 1'b1;
    startJob(8'd8, 8'd2);
    s = '0;
    for (int c = 1; c <= 8; c++) s = s + 28'(c);
    expQ.push_back('{row: '0, data: s});
    for (int c = 1; c <= 8; c++) sendTerm(28'(c), aacSeen, aSeen);
    sendTerm(28'd100, aacSeen, aSeen);
    sendTerm(28'd200, aacSeen, aSeen);
    sendTerm(28'd300, aacSeen, aSeen);
    reset_n   = 1'b0;
    prodValid = 1'b1;
    prodData  = 28'h55;
    #1;
    vectorCount++;
    if ({busy, cfgErr, done, prodReady, aacO, accA, resValid, resData, resRow} !== '0) begin
      missCount++;
      $display("[TB] FAIL midjob_reset_async: got busy %b ready %b aac %b A 0x%07h valid %b, need all 0",
               busy, prodReady, aacO, accA, resValid);
    end
    @(negedge clk);
    vectorCount++;
    if ({busy, cfgErr, done, prodReady, aacO, accA, resValid, resData, resRow} !== '0) begin
      missCount++;
      $display("[TB] FAIL midjob_reset_hold: got busy %b ready %b aac %b A 0x%07h valid %b, need all 0",
               busy, prodReady, aacO, accA, resValid);
    end
    @(posedge clk); #1;
    reset_n   = 1'b1;
    prodValid = 1'b0;
    prodData  = '0;
    @(posedge clk); #1;
    prev = doneCount;
    startJob(8'd2, 8'd1);
    expQ.push_back('{row: '0, data: 28'd3 + 28'd4});
    sendTerm(28'd3, aacSeen, aSeen);
    vectorCount++;
    if (aacSeen !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL midjob_restart_aac: got aac %b, need 0", aacSeen);
    end
    sendTerm(28'd4, aacSeen, aSeen);
    waitDone(prev);
    vectorCount++;
    if (doneCount !== prev + 1) begin
      missCount++;
      $display("[TB] FAIL midjob_done: got %0d pulses, need 1", doneCount - prev);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      vectorCount++;
      if (rdPtr >= obsCount) begin
        missCount++;
        $display("[TB] FAIL midjob_result: got none, need row %0d data 0x%07h", e.row, e.data);
      end else begin
        if (obsRow[rdPtr] !== e.row || obsData[rdPtr] !== e.data) begin
          missCount++;
          $display("[TB] FAIL midjob_result: got row %0d data 0x%07h, need row %0d data 0x%07h",
                   obsRow[rdPtr], obsData[rdPtr], e.row, e.data);
        end
        rdPtr++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_len_one();
    test_backpressure();
    test_cfg_errors();
    test_reset_midjob();
    vectorCount++;
    if (timeoutCount !== 0) begin
      missCount++;
      $display("[TB] FAIL prod_handshake_timeout: got %0d timeouts, need 0", timeoutCount);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
